// File: rtl/nds_dmac_pkg.sv
// Shared DMA channel types: APB writer state encoding, APB control
// bundle constants and beat-size helper used by reader and writer blocks.
package nds_dmac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_DONE   = 3'd4
  } apbw_state_t;

  localparam int unsigned APBW_DATA_WIDTH = 32;
  localparam int unsigned APBW_BYTES = APBW_DATA_WIDTH / 8;

  typedef struct packed {
    logic psel;
    logic penable;
    logic pwrite;
  } apb_ctrl_t;

  localparam apb_ctrl_t APB_CTRL_IDLE   = 3'b000;
  localparam apb_ctrl_t APB_CTRL_SETUP  = 3'b101;
  localparam apb_ctrl_t APB_CTRL_ACCESS = 3'b111;

  function automatic int unsigned apbw_bytes(input int unsigned dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/nds_apbw_addr_gen.sv
// Beat address register and remaining-beat counter for the APB writer.
// Ports: load (base/count), step (advance one beat), addr, last (one left).
module nds_apbw_addr_gen #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int STEP       = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [CNT_WIDTH-1:0]  load_cnt,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  localparam logic [ADDR_WIDTH-1:0] STEP_A = ADDR_WIDTH'(STEP);
  localparam logic [CNT_WIDTH-1:0]  ONE    = CNT_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  rem_q, rem_d;

  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    if (load) begin
      addr_d = load_addr;
      rem_d  = load_cnt;
    end else if (step && rem_q != '0) begin
      // address wraps modulo 2^ADDR_WIDTH
      addr_d = addr_q + STEP_A;
      rem_d  = rem_q - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
    end
  end

  assign addr = addr_q;
  assign last = (rem_q == ONE);

endmodule

// File: rtl/nds_fifo_apb_writer.sv
// Drains a sync FIFO into APB writes at incrementing addresses.
// Ports: start/base_addr/beat_cnt cmd, busy/done/err status, FIFO pop, APB master.
module nds_fifo_apb_writer
  import nds_dmac_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  beat_cnt,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic                  fifo_empty,
  output logic                  fifo_rd,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam int unsigned BYTES = apbw_bytes(DATA_WIDTH);

  apbw_state_t           state_q, state_d;
  apb_ctrl_t             ctrl_q, ctrl_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  ag_load, ag_step, ag_last;
  logic [ADDR_WIDTH-1:0] ag_addr;

  nds_apbw_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .CNT_WIDTH (CNT_WIDTH),
    .STEP      (int'(BYTES))
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .load     (ag_load),
    .step     (ag_step),
    .load_addr(base_addr),
    .load_cnt (beat_cnt),
    .addr     (ag_addr),
    .last     (ag_last)
  );

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    pwdata_d = pwdata_q;
    ag_load  = 1'b0;
    ag_step  = 1'b0;
    fifo_rd  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          ag_load = 1'b1;
          err_d   = 1'b0;
          state_d = (beat_cnt == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (!fifo_empty) begin
          fifo_rd  = 1'b1;
          pwdata_d = fifo_rd_data;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (pready) begin
          if (pslverr) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (ag_last) begin
            state_d = ST_DONE;
          end else begin
            ag_step = 1'b1;
            // pop the next word now to keep beats back-to-back
            if (!fifo_empty) begin
              fifo_rd  = 1'b1;
              pwdata_d = fifo_rd_data;
              state_d  = ST_SETUP;
            end else begin
              state_d = ST_FETCH;
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // a pop during reset would drop a word nobody writes
    if (reset) fifo_rd = 1'b0;
  end

  always_comb begin
    ctrl_d = APB_CTRL_IDLE;
    if (state_d == ST_SETUP) ctrl_d = APB_CTRL_SETUP;
    if (state_d == ST_ACCESS) ctrl_d = APB_CTRL_ACCESS;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ctrl_q   <= APB_CTRL_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      pwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      pwdata_q <= pwdata_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign psel    = ctrl_q.psel;
  assign penable = ctrl_q.penable;
  assign pwrite  = ctrl_q.pwrite;
  assign paddr   = ag_addr;
  assign pwdata  = pwdata_q;

endmodule

// File: tb/tb_nds_fifo_apb_writer.sv
// Bench for nds_fifo_apb_writer: FIFO/APB slave models, per-beat scoreboard.
// Directed scenarios followed by randomized commands.
module tb_nds_fifo_apb_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] beat_cnt = '0;
  logic        busy, done, err;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd;
  logic [31:0] fifo_rd_data = '0;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic        pready = 1'b1;
  logic        pslverr = 1'b0;

  nds_fifo_apb_writer #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .CNT_WIDTH (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .beat_cnt    (beat_cnt),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .fifo_empty  (fifo_empty),
    .fifo_rd     (fifo_rd),
    .fifo_rd_data(fifo_rd_data),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .pready      (pready),
    .pslverr     (pslverr)
  );

  initial forever #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] fq[$];
  logic [31:0] exp_data[$];
  bit          pop_pend = 0;
  int          beats_done = 0;
  int          pops = 0;
  int          psel_cycles = 0;
  int          done_count = 0;
  int          done_cyc = 0;
  logic [31:0] cmd_base = '0;
  int          err_beat = 999;
  int          exp_beats = 0;
  bit          exp_err = 0;
  int          slv_mode = 0;
  int          stall_beat = 0;
  int          stall_len = 0;
  int          fifo_mode = 0;
  logic [31:0] wr_addr[16];
  logic [31:0] wr_data[16];
  bit          in_wait = 0;
  logic [31:0] hold_a, hold_d;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // FIFO and APB slave environment
  initial begin : drv
    int acc_n;
    acc_n = 0;
    forever begin
      @(posedge clk);
      #1;
      if (pop_pend && fq.size() > 0) fq.delete(0);
      pop_pend = 0;
      if (psel && penable) acc_n++;
      else acc_n = 0;
      case (slv_mode)
        0: pready = 1'b1;
        1: pready = ($urandom_range(0, 2) != 0);
        2: pready = !(beats_done == stall_beat && acc_n <= stall_len);
        default: pready = 1'b0;
      endcase
      pslverr = (beats_done == err_beat);
      fifo_empty = (fq.size() == 0) ||
                   (fifo_mode != 0 && $urandom_range(0, 3) == 0);
      fifo_rd_data = (fq.size() > 0) ? fq[0] : '0;
    end
  end

  // compare process: protocol rules and per-beat scoreboard
  initial begin : mon
    logic [31:0] exp_a;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_wait = 0;
        pop_pend = 0;
      end else begin
        chk("pwrite_eq_psel", pwrite, psel);
        chk("penable_wo_psel", penable & ~psel, 0);
        chk("pop_when_empty", fifo_rd & fifo_empty, 0);
        chk("pop_in_setup", fifo_rd & psel & ~penable, 0);
        pop_pend = fifo_rd;
        if (fifo_rd) pops++;
        if (psel) psel_cycles++;
        if (in_wait && psel && penable) begin
          chk("hold_paddr", paddr, hold_a);
          chk("hold_pwdata", pwdata, hold_d);
        end
        if (psel && penable && pready) begin
          exp_a = cmd_base + 32'(beats_done * 4);
          chk("beat_paddr", paddr, exp_a);
          checks++;
          if (exp_data.size() == 0) begin
            errors++;
            $display("FAIL beat_pwdata: got %0h, required no beat", pwdata);
          end else begin
            if (pwdata !== exp_data[0]) begin
              errors++;
              $display("FAIL beat_pwdata: got %0h, required %0h",
                       pwdata, exp_data[0]);
            end
            exp_data.delete(0);
          end
          if (beats_done < 16) begin
            wr_addr[beats_done] = paddr;
            wr_data[beats_done] = pwdata;
          end
          beats_done++;
        end
        in_wait = psel & penable & ~pready;
        hold_a = paddr;
        hold_d = pwdata;
        if (done) begin
          done_count++;
          done_cyc = cyc;
          chk("done_err", err, exp_err);
          chk("done_beats", beats_done, exp_beats);
          chk("done_pops", pops, exp_beats);
          chk("busy_in_done", busy, 1);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  task automatic push_words(input int n, input logic [31:0] first,
                            input bit rnd);
    for (int i = 0; i < n; i++) begin
      logic [31:0] w;
      w = rnd ? $urandom : first + 32'(i);
      fq.push_back(w);
      exp_data.push_back(w);
    end
  endtask

  task automatic flush();
    fq.delete();
    exp_data.delete();
  endtask

  task automatic run_cmd(input logic [31:0] b, input int cnt, input int eb,
                         output int t);
    cmd_base = b;
    err_beat = eb;
    exp_err = (eb < cnt);
    exp_beats = (eb < cnt) ? eb + 1 : cnt;
    beats_done = 0;
    pops = 0;
    psel_cycles = 0;
    done_count = 0;
    start = 1'b1;
    base_addr = b;
    beat_cnt = 16'(cnt);
    t = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_count == 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (done_count == 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done in %0d cycles, required 1",
               budget);
    end else begin
      chk("done_one_cycle", done, 0);
    end
  endtask

  initial begin : main
    int t;
    int cnt;
    int eb;
    int n;
    logic [31:0] b;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_fifo_rd", fifo_rd, 0);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // four beats, zero-wait slave
    push_words(4, 32'hA0, 0);
    @(posedge clk);
    #1;
    run_cmd(32'h1000, 4, 999, t);
    wait_done(100);
    chk("t1_done_cycle", done_cyc, t + 10);
    chk("t1_psel_cycles", psel_cycles, 8);
    chk("t1_busy_low", busy, 0);
    chk("t1_addr0", wr_addr[0], 32'h1000);
    chk("t1_addr3", wr_addr[3], 32'h100C);
    chk("t1_data0", wr_data[0], 32'hA0);
    chk("t1_data3", wr_data[3], 32'hA3);
    chk("t1_err", err, 0);

    // zero-beat command
    run_cmd(32'h2000, 0, 999, t);
    wait_done(20);
    chk("t2_done_cycle", done_cyc, t + 1);
    chk("t2_psel_cycles", psel_cycles, 0);
    chk("t2_pops", pops, 0);

    // FIFO empty at start, word arrives later
    run_cmd(32'h3000, 1, 999, t);
    repeat (5) @(posedge clk);
    #1;
    chk("t3_wait_psel", psel_cycles, 0);
    chk("t3_wait_busy", busy, 1);
    chk("t3_wait_pops", pops, 0);
    push_words(1, 32'hC5, 0);
    wait_done(50);
    chk("t3_beats", beats_done, 1);
    chk("t3_data", wr_data[0], 32'hC5);
    chk("t3_err", err, 0);

    // three wait states on beat 2 of 3
    push_words(3, 32'hB0, 0);
    @(posedge clk);
    #1;
    slv_mode = 2;
    stall_beat = 1;
    stall_len = 3;
    run_cmd(32'h4000, 3, 999, t);
    wait_done(100);
    chk("t4_psel_cycles", psel_cycles, 9);
    chk("t4_done_cycle", done_cyc, t + 11);
    slv_mode = 0;

    // slave error on beat 2 of 4
    push_words(4, 32'hD0, 0);
    @(posedge clk);
    #1;
    run_cmd(32'h5000, 4, 1, t);
    wait_done(100);
    chk("t5_err_sticky", err, 1);
    chk("t5_left_in_fifo", fq.size(), 2);
    flush();
    push_words(1, 32'hE0, 0);
    @(posedge clk);
    #1;
    run_cmd(32'h5100, 1, 999, t);
    chk("t5_err_cleared", err, 0);
    wait_done(50);

    // address wrap
    push_words(2, 32'hF0, 0);
    @(posedge clk);
    #1;
    run_cmd(32'hFFFF_FFFC, 2, 999, t);
    wait_done(50);
    chk("t6_addr0", wr_addr[0], 32'hFFFF_FFFC);
    chk("t6_addr1", wr_addr[1], 32'h0000_0000);

    // reset during ACCESS
    push_words(3, 32'h70, 0);
    @(posedge clk);
    #1;
    slv_mode = 3;
    run_cmd(32'h7000, 3, 999, t);
    n = 0;
    while (!(psel && penable) && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t7_reached_access", psel & penable, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("t7_rst_psel", psel, 0);
    chk("t7_rst_penable", penable, 0);
    chk("t7_rst_busy", busy, 0);
    reset = 1'b0;
    flush();
    slv_mode = 0;
    @(posedge clk);
    #1;
    push_words(2, 32'h78, 0);
    @(posedge clk);
    #1;
    run_cmd(32'h7100, 2, 999, t);
    wait_done(50);
    chk("t7_done_cycle", done_cyc, t + 6);
    chk("t7_data1", wr_data[1], 32'h79);

    // randomized commands
    slv_mode = 1;
    fifo_mode = 1;
    for (int k = 0; k < 25; k++) begin
      cnt = $urandom_range(0, 8);
      b = $urandom & 32'hFFFF_FFFC;
      if (k % 5 == 0) b = 32'hFFFF_FFF0;
      eb = 999;
      if (cnt > 0 && $urandom_range(0, 3) == 0)
        eb = $urandom_range(0, cnt - 1);
      push_words(cnt, 32'h0, 1);
      @(posedge clk);
      #1;
      run_cmd(b, cnt, eb, t);
      wait_done(600);
      chk("rnd_busy_low", busy, 0);
      flush();
      @(posedge clk);
      #1;
    end
    slv_mode = 0;
    fifo_mode = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nds_fifo_apb_writer.md
# nds_fifo_apb_writer

Drain side of the DMA channel data path: pops words from a synchronous data FIFO (head-of-queue `rd_data`, `rd`/`empty` handshake) and issues them as APB write transfers to incrementing addresses. Software or the channel controller programs a base address and beat count, then pulses `start`. The block sits between the channel FIFO and the APB requester port and reports completion or slave error back to the channel controller.

## Interface
- `DATA_WIDTH`, 32, APB data and FIFO word width; 32 or 64 only.
- `ADDR_WIDTH`, 32, APB address width.
- `CNT_WIDTH`, 16, beat-count width.

- `clk` input 1 single clock for all logic.
- `reset` input 1 synchronous, active-high reset.
- `start` input 1 one-cycle command strobe, sampled only in IDLE.
- `base_addr` input ADDR_WIDTH first beat address, sampled with `start`; must be aligned to DATA_WIDTH/8.
- `beat_cnt` input CNT_WIDTH number of words to transfer, sampled with `start`.
- `busy` output 1 high from the cycle after an accepted `start` through the DONE cycle.
- `done` output 1 one-cycle pulse at command end, for success or error.
- `err` output 1 sticky slave-error flag; cleared by the next accepted `start`.
- `fifo_empty` input 1 FIFO empty flag.
- `fifo_rd` output 1 pop strobe; asserted only when `fifo_empty`=0.
- `fifo_rd_data` input DATA_WIDTH FIFO head word, combinational and valid while `fifo_empty`=0.
- `psel`, `penable`, `pwrite` output 1 each APB control; `pwrite` is 1 whenever `psel`=1.
- `paddr` output ADDR_WIDTH APB address.
- `pwdata` output DATA_WIDTH APB write data.
- `pready`, `pslverr` input 1 each APB completion and error.

## Operation
- **States:** IDLE, FETCH, SETUP, ACCESS, DONE.
- **IDLE:** on `start`:
  - latch `base_addr` into the address register and `beat_cnt` into `remaining`; clear `err`.
  - `beat_cnt`=0 goes to DONE (no APB transfer, no pop); otherwise go to FETCH.
  - `start` in any other state is ignored.
- **FETCH:** while `fifo_empty`=1, wait indefinitely.
  - When `fifo_empty`=0: assert `fifo_rd`, register `fifo_rd_data` into `pwdata`, go to SETUP.
- **SETUP:** `psel`=1, `penable`=0. Always go to ACCESS next cycle.
- **ACCESS:** `psel`=1, `penable`=1. Hold `paddr` and `pwdata` until `pready`=1.
- **On `pready`=1 in ACCESS:**
  - `pslverr`=1: set `err`, go to DONE. Remaining FIFO words are not popped.
  - else if `remaining`=1: go to DONE.
  - else: decrement `remaining` and add DATA_WIDTH/8 to the address (modulo 2^ADDR_WIDTH, wrap allowed).
    - if `fifo_empty`=0 in the same cycle: pop, load `pwdata`, go straight to SETUP (back-to-back beats).
    - otherwise go to FETCH.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **`reset`:** all state returns to IDLE at the next edge, including mid-transfer. An APB transfer in flight is abandoned; `psel` drops.

## Timing
- **Reset values:** `busy`, `done`, `err`, `fifo_rd`, `psel`, `penable`, `pwrite` = 0; `paddr`, `pwdata` = 0.
- **Outputs:** all registered except `fifo_rd`, which is combinational from state, `fifo_empty` and `pready`.
- **Start latency:** `start` at cycle T with FIFO non-empty gives FETCH at T+1 (pop), SETUP at T+2, first ACCESS at T+3.
- **Throughput:** 2 cycles/beat with zero-wait slaves and a non-empty FIFO; each extra cycle of `pready`=0 adds one.
- **Last beat:** `pready` at cycle T gives `done`=1 at T+1 and `busy`=0 at T+2.
- **Pop rule:** at most one `fifo_rd` per beat; never in SETUP, DONE or IDLE.
- **`remaining`:** CNT_WIDTH bits, never underflows; `beat_cnt` maximum is 2^CNT_WIDTH-1.

## Structure
- **Shared package `nds_dmac_pkg`:**
  - state encoding typedef `apbw_state_t`.
  - localparam `APBW_BYTES = DATA_WIDTH/8`.
  - APB control bundle constants shared with the reader-side block.
- **One sub-module:** `nds_apbw_addr_gen` (address register plus `remaining` counter, with load, step and last outputs). The FSM stays in the top module.

## Test plan
- `base_addr`=0x1000, `beat_cnt`=4, FIFO preloaded 0xA0..0xA3, `pready` tied 1:
  - writes 0xA0..0xA3 to 0x1000/0x1004/0x1008/0x100C.
  - 2-cycle beat spacing; `done` at cycle 10 after `start`; 4 pops.
- `beat_cnt`=0 -> `done` at T+1, no `psel`, no `fifo_rd`.
- FIFO empty at start, one word pushed 5 cycles later -> FSM holds FETCH with `psel`=0, then completes a single write; `err`=0.
- `pready` low for 3 cycles on beat 2 of 3 -> `paddr`/`pwdata` stable through the wait, total 9 cycles of APB activity.
- `pslverr`=1 on beat 2 of 4 -> `err`=1, `done` pulse, exactly 2 pops; next `start` clears `err`.
- `base_addr`=0xFFFF_FFFC, `beat_cnt`=2 -> second `paddr`=0x0000_0000.
- `reset` asserted during ACCESS -> next edge `psel`=0, `busy`=0; a new `start` runs normally.
